// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: measures the interval between rising edges of an
// asynchronous heartbeat, locks after LOCK_CNT consecutive in-tolerance
// beats, and flags early or missing beats while locked.
module heartbeat_monitor #(
  parameter int N        = 8,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 4
) (
  inout  wire          vccd1,
  inout  wire          vssd1,
  input  logic         clk,
  input  logic         nreset,
  input  logic         hb_in,
  input  logic         clr_err,
  output logic         locked,
  output logic         err_miss,
  output logic         err_early,
  output logic [N+1:0] period,
  output logic [7:0]   fault_count
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  localparam int unsigned  NOM      = 1 << N;
  localparam logic [N+1:0] P_LO     = (N+2)'(NOM - TOL);
  localparam logic [N+1:0] P_HI     = (N+2)'(NOM + TOL);
  localparam logic [N+1:0] CNT_ONE  = (N+2)'(1);
  localparam logic [N+1:0] CNT_MAX  = '1;
  localparam int           GW       = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0] GCNT_ONE = GW'(1);
  localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);

  // Supply pins only exist for the power grid; no logic depends on them.
  wire unused_supply;
  assign unused_supply = vccd1 ^ vssd1;

  logic          s1, s2, s3;
  logic          beat;
  logic [N+1:0]  cnt_reg;
  logic          timeout;
  logic          good;
  logic          early;
  state_t        state_reg, state_next;
  logic [GW-1:0] gcnt_reg, gcnt_next, gcnt_inc;
  logic          miss_next, early_next;
  logic          err_any;

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= hb_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Beat qualification from the interval counter value before its update.
  always_comb begin
    beat    = s2 & ~s3;
    good    = (cnt_reg >= P_LO) && (cnt_reg <= P_HI);
    early   = (cnt_reg < P_LO);
    timeout = ~beat && (cnt_reg == P_HI);
    err_any = miss_next | early_next;
  end

  assign gcnt_inc = gcnt_reg + GCNT_ONE;

  // Interval counter: restarts at 1 on a beat, otherwise saturating count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_reg <= '0;
    end else if (beat) begin
      cnt_reg <= CNT_ONE;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + CNT_ONE;
    end
  end

  // Next-state logic; a beat always takes priority over a timeout.
  always_comb begin
    state_next = state_reg;
    gcnt_next  = gcnt_reg;
    miss_next  = 1'b0;
    early_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (beat) begin
          state_next = ACQUIRE;
          gcnt_next  = '0;
        end
      end
      ACQUIRE: begin
        if (beat) begin
          if (good) begin
            gcnt_next = gcnt_inc;
            if (gcnt_inc == LOCK_V) state_next = LOCKED;
          end else begin
            gcnt_next = '0;
          end
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (beat) begin
          if (early) begin
            state_next = LOST;
            early_next = 1'b1;
          end
        end else if (timeout) begin
          state_next = LOST;
          miss_next  = 1'b1;
        end
      end
      LOST: begin
        if (beat) begin
          state_next = ACQUIRE;
          gcnt_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg <= IDLE;
      gcnt_reg  <= '0;
      locked    <= 1'b0;
      err_miss  <= 1'b0;
      err_early <= 1'b0;
      period    <= '0;
    end else begin
      state_reg <= state_next;
      gcnt_reg  <= gcnt_next;
      locked    <= (state_next == LOCKED);
      err_miss  <= miss_next;
      err_early <= early_next;
      if (beat && (state_reg != IDLE)) period <= cnt_reg;
    end
  end

  // Saturating fault counter; a clear on an error cycle leaves that error counted.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      fault_count <= 8'd0;
    end else if (clr_err) begin
      fault_count <= err_any ? 8'd1 : 8'd0;
    end else if (err_any && (fault_count != 8'hFF)) begin
      fault_count <= fault_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor: lock, jitter, missing beat,
// re-acquisition, reset mid-operation, and fault counter saturation/clear
// (the latter on a small-period instance to keep the run short).
module tb_heartbeat_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  wire vccd1;
  wire vssd1;
  assign vccd1 = 1'b1;
  assign vssd1 = 1'b0;

  logic       nreset, hb_in, clr_err;
  logic       locked, err_miss, err_early;
  logic [9:0] period;
  logic [7:0] fault_count;

  logic       hb2, clr2;
  logic       locked2, err_miss2, err_early2;
  logic [3:0] period2;
  logic [7:0] fault_count2;

  heartbeat_monitor #(.N(8), .TOL(2), .LOCK_CNT(4)) dut (
    .vccd1(vccd1), .vssd1(vssd1), .clk(clk), .nreset(nreset),
    .hb_in(hb_in), .clr_err(clr_err), .locked(locked),
    .err_miss(err_miss), .err_early(err_early),
    .period(period), .fault_count(fault_count)
  );

  heartbeat_monitor #(.N(2), .TOL(0), .LOCK_CNT(1)) dut2 (
    .vccd1(vccd1), .vssd1(vssd1), .clk(clk), .nreset(nreset),
    .hb_in(hb2), .clr_err(clr2), .locked(locked2),
    .err_miss(err_miss2), .err_early(err_early2),
    .period(period2), .fault_count(fault_count2)
  );

  int checks = 0;
  int failures = 0;
  int n_miss = 0;
  int n_early = 0;
  int beat_no = 0;

  // Count error pulses of the main instance shortly after each edge.
  always @(posedge clk) begin
    #1;
    if (err_miss === 1'b1) n_miss++;
    if (err_early === 1'b1) n_early++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise hb_in 'gap' cycles after the previous raise; returns on the
  // falling edge right after the resulting beat edge.
  task automatic beat_after(input int gap);
    repeat (gap - 3) @(negedge clk);
    hb_in = 1'b1;
    @(negedge clk);
    hb_in = 1'b0;
    repeat (2) @(negedge clk);
    beat_no++;
    $display("beat %0d gap=%0d locked=%0d period=%0d faults=%0d",
             beat_no, gap, locked, period, fault_count);
  endtask

  // One-cycle pulse on the small instance, next raise 'gap' cycles later.
  task automatic pulse2(input int gap);
    hb2 = 1'b1;
    @(negedge clk);
    hb2 = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; hb_in = 1'b0; clr_err = 1'b0; hb2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_err_miss", err_miss, 0);
    check("rst_err_early", err_early, 0);
    check("rst_period", period, 0);
    check("rst_fault_count", fault_count, 0);
    nreset = 1'b1;

    // Lock acquisition at the nominal 256-cycle period.
    for (int b = 1; b <= 5; b++) begin
      beat_after(b == 1 ? 20 : 256);
      check($sformatf("lock_beat%0d", b), locked, (b == 5) ? 1 : 0);
    end
    check("lock_period", period, 256);
    check("lock_no_errors", n_miss + n_early, 0);

    // Jitter tolerance at both edges of the window, then an early beat.
    beat_after(254);
    check("jit254_locked", locked, 1);
    check("jit254_period", period, 254);
    beat_after(258);
    check("jit258_locked", locked, 1);
    check("jit258_period", period, 258);
    check("jit258_no_miss", n_miss, 0);
    beat_after(253);
    check("early_pulse", err_early, 1);
    check("early_no_miss", err_miss, 0);
    check("early_locked", locked, 0);
    check("early_period", period, 253);
    check("early_faults", fault_count, 1);
    @(negedge clk);
    check("early_one_cycle", err_early, 0);

    // Re-acquisition from LOST.
    for (int b = 1; b <= 5; b++) begin
      beat_after(256);
      check($sformatf("reacq_beat%0d", b), locked, (b == 5) ? 1 : 0);
    end
    check("reacq_early_count", n_early, 1);

    // Missing beat: err_miss exactly 258 edges after the last beat edge.
    repeat (257) @(negedge clk);
    check("miss_not_yet", err_miss, 0);
    check("miss_still_locked", locked, 1);
    @(negedge clk);
    check("miss_pulse", err_miss, 1);
    check("miss_locked", locked, 0);
    check("miss_faults", fault_count, 2);
    repeat (600) @(negedge clk);
    check("miss_once", n_miss, 1);

    // Lock again, then reset while locked.
    for (int b = 1; b <= 5; b++) beat_after(256);
    check("relock", locked, 1);
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_period", period, 0);
    check("mid_rst_faults", fault_count, 0);
    check("mid_rst_err_miss", err_miss, 0);
    check("mid_rst_err_early", err_early, 0);
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    beat_after(20);
    check("post_rst_idle_period", period, 0);
    check("post_rst_locked", locked, 0);
    for (int b = 2; b <= 5; b++) begin
      beat_after(256);
      if (b == 2) check("post_rst_period", period, 256);
      check($sformatf("post_rst_beat%0d", b), locked, (b == 5) ? 1 : 0);
    end
    check("post_rst_no_err", n_miss + n_early, 2);

    // Fault counter saturation on the fast instance: 300 early faults.
    for (int i = 0; i < 300; i++) begin
      pulse2(4);
      pulse2(2);
      pulse2(2);
    end
    repeat (6) @(negedge clk);
    $display("fast instance after 300 faults: faults=%0d", fault_count2);
    check("sat_faults", fault_count2, 255);
    check("sat_locked", locked2, 0);

    // Clear coinciding with an error pulse leaves a count of one.
    pulse2(4);
    pulse2(2);
    hb2 = 1'b1;
    @(negedge clk);
    hb2 = 1'b0;
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    check("clr_coincide_pulse", err_early2, 1);
    check("clr_coincide_faults", fault_count2, 1);
    @(negedge clk);
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    check("clr_plain_faults", fault_count2, 0);
    $display("clear sequence done: faults=%0d", fault_count2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
